riscv_ifetch: RTL

- Instruction fetch front end. It owns the fetch program counter, issues in-order word-fetch requests to instruction memory, and buffers the returned instructions with their PCs.
- It hands the buffered instructions to decode over a valid/ready interface.
- It accepts redirects from execute (branch, jump, trap) and discards stale in-flight responses, so decode only ever sees the correct-path instruction stream.

---
 rtl/riscv_ifetch.sv | 138 +++++++++++++
 1 files changed

// File: rtl/riscv_ifetch.sv
// riscv_ifetch: instruction fetch front end.
//
// Owns the fetch PC, issues in-order word fetches to instruction memory and
// buffers the returned instructions (with their PCs) in a small FIFO that
// feeds decode over a valid/ready handshake. Redirects from execute restart
// fetch at a new PC; responses to requests issued before the redirect are
// counted off and discarded so decode only sees the correct-path stream.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   redirect_valid_i    redirect fetch this cycle (highest priority)
//   redirect_pc_i       new fetch PC, bits [1:0] ignored
//   imem_req_valid_o    fetch request valid
//   imem_req_ready_i    memory accepts request
//   imem_req_addr_o     word-aligned fetch address
//   imem_rsp_valid_i    response valid (in request order, always accepted)
//   imem_rsp_data_i     fetched instruction
//   inst_valid_o        buffered instruction available
//   inst_ready_i        decode consumes instruction
//   inst_o, inst_pc_o   instruction at buffer head and its PC

module riscv_ifetch #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid_i,
  input  logic [63:0] redirect_pc_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [63:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [63:0] inst_pc_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  logic [63:0]   fetch_pc;
  logic [63:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_cnt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [63:0]   pc_mem   [FIFO_DEPTH];
  logic [31:0]   inst_mem [FIFO_DEPTH];

  logic          fifo_empty;
  logic          pop;
  logic          do_pop;
  logic          push;
  logic          rsp_drop;
  logic          req_hs;
  logic [CW:0]   credit_used;
  logic [63:0]   redirect_pc;
  logic          unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc_i[1:0];
  assign redirect_pc    = {redirect_pc_i[63:2], 2'b00};

  assign fifo_empty = (fifo_cnt == '0);
  assign pop        = !rst && !fifo_empty && inst_ready_i;
  assign do_pop     = pop && !redirect_valid_i;

  // Every issued request reserves a FIFO slot up front, so a response can
  // always be written. A slot freed by this cycle's pop counts as available.
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_cnt} - {{CW{1'b0}}, pop};

  assign imem_req_valid_o = !rst && !redirect_valid_i && (credit_used < DEPTH_W);
  assign imem_req_addr_o  = fetch_pc;
  assign req_hs           = imem_req_valid_o && imem_req_ready_i;

  assign rsp_drop = imem_rsp_valid_i && (drop_cnt != '0);
  assign push     = !rst && imem_rsp_valid_i && (drop_cnt == '0) && !redirect_valid_i;

  assign inst_valid_o = !rst && !fifo_empty;
  assign inst_o       = rst ? 32'h0 : inst_mem[rd_ptr];
  assign inst_pc_o    = rst ? 64'h0 : pc_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      // No request is issued during a redirect, so this also covers that case.
      outstanding <= outstanding + CW'(req_hs) - CW'(imem_rsp_valid_i);

      if (redirect_valid_i) begin
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        fifo_cnt <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        // Every request still in flight is now stale. drop_cnt is a subset
        // of outstanding, so the new drop count is all remaining in-flight
        // requests (minus one if a response lands this cycle and is eaten
        // here). This keeps back-to-back redirects from double counting.
        drop_cnt <= outstanding - CW'(imem_rsp_valid_i);
      end else begin
        if (req_hs) begin
          fetch_pc <= fetch_pc + 64'd4;
        end
        if (rsp_drop) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
        if (push) begin
          rsp_pc <= rsp_pc + 64'd4;
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (do_pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        fifo_cnt <= fifo_cnt + CW'(push) - CW'(do_pop);
      end
    end
  end

  // Buffer storage needs no reset; fifo_cnt gates visibility of its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= rsp_pc;
      inst_mem[wr_ptr] <= imem_rsp_data_i;
    end
  end

endmodule
